uart_tx_frame_ctrl: RTL
=======================

// Module: uart_tx_frame_ctrl
// PURPOSE
//  Frame controller for the UART transmitter. Sits downstream of the serializer, which it drives.
//  Accepts a parallel word on Data_Valid and sequences START, DATA (enables the serializer), optional
//  PARITY and STOP. Muxes the frame onto TX_OUT at one bit per CLK, where CLK is the TX bit clock.
//  Busy feeds back to the serializer and to the upstream data source.
// PARAMETERS
//  Data_Width  8  bits per frame; must equal the width of the serializer it drives
// PORTS
//  CLK         in   1           TX bit clock; single clock domain
//  RST         in   1           synchronous, active-high reset
//  P_DATA      in   Data_Width  parallel word; sampled for parity on acceptance
//  Data_Valid  in   1           request to send P_DATA; accepted only while Busy=0
//  PAR_EN      in   1           1 = insert parity bit; sampled on acceptance
//  PAR_TYP     in   1           0 = even parity, 1 = odd parity; sampled on acceptance
//  Ser_Data    in   1           current serial bit from the serializer
//  Ser_En      out  1           shift enable to the serializer; high only in DATA
//  Busy        out  1           frame in progress; high in START/DATA/PARITY/STOP
//  TX_OUT      out  1           UART line; idle-high
//  TX_Done     out  1           one-cycle pulse during the final STOP cycle
// BEHAVIOUR
//  - Reset (RST=1 at posedge): state=IDLE, bit counter=0, latched parity/config=0.
//    Resulting outputs: Ser_En=0, Busy=0, TX_OUT=1, TX_Done=0.
//  - Reset mid-frame aborts immediately. Line returns high the cycle after the reset edge.
//    Ser_En drops, so the serializer clears itself. No TX_Done is issued.
//  - Outputs are a combinational decode of state and registered sources (state, counter, parity
//    register, Ser_Data) only. There is no combinational path from any other input to an output.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE:   TX_OUT=1. If Data_Valid=1, go to START. On that edge:
//            latch par_bit = ^P_DATA ^ PAR_TYP; latch PAR_EN; clear the counter.
//    START:  TX_OUT=0 for 1 cycle, then go to DATA.
//    DATA:   Ser_En=1, TX_OUT=Ser_Data, counter += 1 per cycle.
//            After Data_Width cycles (counter == Data_Width-1), go to PARITY if the latched PAR_EN=1,
//            otherwise go to STOP.
//    PARITY: TX_OUT = latched par_bit for 1 cycle, then go to STOP.
//    STOP:   TX_OUT=1, TX_Done=1 for 1 cycle, then go to IDLE.
//  - Data is sent LSB first. The serializer presents bit0 in the first DATA cycle and shifts on each
//    Ser_En edge.
//  - Latency: Data_Valid sampled in IDLE at edge N means START is on the line in cycle N+1.
//    Busy=1 from cycle N+1 through the STOP cycle.
//  - Frame length: 1 + Data_Width + PAR_EN + 1 cycles (11 with parity, 10 without, at Data_Width=8).
//  - Data_Valid while Busy=1 is ignored. There is no queue, and the word is not replayed later.
//  - P_DATA, PAR_EN and PAR_TYP changes mid-frame have no effect on the current frame.
//  - Back-to-back: if Data_Valid is held high, the next frame is accepted in the IDLE cycle after STOP.
//    This gives one extra high bit between frames (minimum inter-frame gap = 1 cycle).
//  - Counter width = $clog2(Data_Width). The counter never wraps inside DATA; it is cleared on acceptance.
// TESTING
//  1. After reset: Busy=0, TX_OUT=1, Ser_En=0, TX_Done=0. Hold for 5 cycles; outputs are unchanged.
//  2. P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, 1-cycle Data_Valid:
//     TX_OUT = 0,1,0,1,0,0,1,0,1,0(par),1(stop). Busy high for 11 cycles. Ser_En high for 8 cycles.
//  3. Same word with PAR_TYP=1: parity bit = 1. With PAR_EN=0: 10-cycle frame with no parity slot.
//     TX_Done pulses once, in the stop cycle.
//  4. Data_Valid pulsed mid-DATA with P_DATA=8'hFF: no effect. Line carries the original 8'hA5 frame,
//     then IDLE.
//  5. Data_Valid held high with P_DATA=8'h3C: frames repeat with exactly 1 idle-high cycle between
//     STOP and the next START.
//  6. RST asserted in the 4th DATA cycle: the next cycle shows Busy=0, Ser_En=0, TX_OUT=1, no TX_Done.
//     A new 8'h01 frame then transmits correctly.

Source files
------------

// File: rtl/uart_tx_frame_ctrl_if.sv
// Frame-controller bus: upstream word handshake, serializer link and UART line.
// master = data source / serializer side, slave = frame controller.
interface uart_tx_frame_ctrl_if #(
  parameter int Data_Width = 8
);
  logic [Data_Width-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  Ser_Data;
  logic                  Ser_En;
  logic                  Busy;
  logic                  TX_OUT;
  logic                  TX_Done;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Ser_Data,
    input  Ser_En, Busy, TX_OUT, TX_Done
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Ser_Data,
    output Ser_En, Busy, TX_OUT, TX_Done
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: sequences START / DATA / PARITY / STOP around an
// external serializer and muxes the frame onto the idle-high line, one bit per CLK.
module uart_tx_frame_ctrl #(
  parameter int Data_Width = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_frame_ctrl_if.slave  bus
);
  localparam int CW = (Data_Width > 1) ? $clog2(Data_Width) : 1;
  localparam logic [CW-1:0] LAST = CW'(Data_Width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          par_bit;
  logic          par_en_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Data_Valid) begin
          // Frame config is frozen here; later input changes cannot disturb it.
          state    <= START;
          par_bit  <= (^bus.P_DATA) ^ bus.PAR_TYP;
          par_en_q <= bus.PAR_EN;
          cnt      <= '0;
        end
        START: state <= DATA;
        DATA: begin
          if (cnt == LAST) state <= par_en_q ? PARITY : STOP;
          else             cnt   <= cnt + 1'b1;
        end
        PARITY:  state <= STOP;
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Pure decode of registered state; Ser_Data is itself a registered source.
  always_comb begin
    bus.Ser_En  = (state == DATA);
    bus.Busy    = (state != IDLE);
    bus.TX_Done = (state == STOP);
    case (state)
      START:   bus.TX_OUT = 1'b0;
      DATA:    bus.TX_OUT = bus.Ser_Data;
      PARITY:  bus.TX_OUT = par_bit;
      default: bus.TX_OUT = 1'b1;
    endcase
  end
endmodule
